// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access sizes, extension
// modes and controller state encodings.
package data_mem_ctrl_pkg;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

    localparam logic MEM_EXT_SIGN = 1'b0;
    localparam logic MEM_EXT_ZERO = 1'b1;

    typedef enum logic [1:0] {
        DMC_IDLE  = 2'b00,
        DMC_RWAIT = 2'b01,
        DMC_RESP  = 2'b10
    } dmc_state_e;

endpackage

// File: rtl/data_mem_ctrl_load_formatter.sv
// Load result formatter: picks the addressed byte/half lane out of an SRAM
// word and sign- or zero-extends it to 32 bits.
module load_formatter
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        ext,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension
    always_comb begin
        byte_s = word[{offset, 3'b000} +: 8];
        if (offset[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (size)
            MEM_SIZE_BYTE: begin
                if (ext == MEM_EXT_ZERO) begin
                    result = {24'h000000, byte_s};
                end else begin
                    result = {{24{byte_s[7]}}, byte_s};
                end
            end
            MEM_SIZE_HALF: begin
                if (ext == MEM_EXT_ZERO) begin
                    result = {16'h0000, half_s};
                end else begin
                    result = {{16{half_s[15]}}, half_s};
                end
            end
            MEM_SIZE_WORD: result = word;
            default:       result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// CPU data-memory responder: turns held load/store requests into byte-lane
// SRAM accesses and returns a registered one-cycle ready pulse.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [1:0]            memDataSize,
    input  logic                  memBitExt,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  err,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY);

    dmc_state_e  state_r, state_nxt_s;
    logic [1:0]  cnt_r;
    logic [1:0]  size_r;
    logic        ext_r;
    logic [1:0]  off_r;
    logic [31:0] rdata_r;
    logic        ready_r;
    logic        err_r;

    logic        req_s, bad_s;
    logic        en_s, latch_s, capture_s, ready_nxt_s, err_nxt_s;
    logic [3:0]  we_s, lane_we_s;
    logic [31:0] fmt_s;
    logic        unused_addr_s;

    assign rdata         = rdata_r;
    assign ready         = ready_r;
    assign err           = err_r;
    assign mem_addr      = addr[ADDR_WIDTH+1:2];
    assign unused_addr_s = ^{addr[31:ADDR_WIDTH+2]};
    // Gated by rst_n so a request held through reset never reaches the SRAM
    assign mem_en        = en_s & rst_n;
    assign mem_we        = we_s & {4{rst_n}};

    // Store lane enables and lane-replicated store data
    always_comb begin
        case (memDataSize)
            MEM_SIZE_BYTE: begin
                lane_we_s = 4'b0001 << addr[1:0];
                mem_wdata = {4{wdata[7:0]}};
            end
            MEM_SIZE_HALF: begin
                if (addr[1]) begin
                    lane_we_s = 4'b1100;
                end else begin
                    lane_we_s = 4'b0011;
                end
                mem_wdata = {2{wdata[15:0]}};
            end
            MEM_SIZE_WORD: begin
                lane_we_s = 4'b1111;
                mem_wdata = wdata;
            end
            default: begin
                lane_we_s = 4'b0000;
                mem_wdata = wdata;
            end
        endcase
    end

    // Request legality check
    always_comb begin
        req_s = memRead | memWrite;
        bad_s = (memRead & memWrite)
              | (memDataSize == 2'b11)
              | ((memDataSize == MEM_SIZE_WORD) & (addr[1:0] != 2'b00))
              | ((memDataSize == MEM_SIZE_HALF) & addr[0]);
    end

    // Next-state and issue decode
    always_comb begin
        state_nxt_s = state_r;
        en_s        = 1'b0;
        we_s        = 4'b0000;
        latch_s     = 1'b0;
        capture_s   = 1'b0;
        ready_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            DMC_IDLE: begin
                if (req_s) begin
                    if (bad_s) begin
                        state_nxt_s = DMC_RESP;
                        ready_nxt_s = 1'b1;
                        err_nxt_s   = 1'b1;
                    end else if (memWrite) begin
                        en_s        = 1'b1;
                        we_s        = lane_we_s;
                        state_nxt_s = DMC_RESP;
                        ready_nxt_s = 1'b1;
                    end else begin
                        en_s        = 1'b1;
                        latch_s     = 1'b1;
                        state_nxt_s = DMC_RWAIT;
                    end
                end else begin
                    state_nxt_s = DMC_IDLE;
                end
            end
            DMC_RWAIT: begin
                if (cnt_r == 2'd1) begin
                    capture_s   = 1'b1;
                    ready_nxt_s = 1'b1;
                    state_nxt_s = DMC_RESP;
                end else begin
                    state_nxt_s = DMC_RWAIT;
                end
            end
            DMC_RESP: state_nxt_s = DMC_IDLE;
            default:  state_nxt_s = DMC_IDLE;
        endcase
    end

    load_formatter u_fmt (
        .word   (mem_rdata),
        .size   (size_r),
        .offset (off_r),
        .ext    (ext_r),
        .result (fmt_s)
    );

    // State, load context and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DMC_IDLE;
            cnt_r   <= 2'd0;
            size_r  <= 2'b00;
            ext_r   <= 1'b0;
            off_r   <= 2'b00;
            rdata_r <= 32'h0000_0000;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= ready_nxt_s;
            err_r   <= err_nxt_s;
            if (latch_s) begin
                size_r <= memDataSize;
                ext_r  <= memBitExt;
                off_r  <= addr[1:0];
                cnt_r  <= LAT_INIT;
            end else if (state_r == DMC_RWAIT) begin
                cnt_r <= cnt_r - 2'd1;
            end
            if (capture_s) begin
                rdata_r <= fmt_s;
            end
        end
    end

endmodule
